rv32_multicycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It consumes the decoded control flags from the instruction decoder and drives the enables for the PC, IR, ALU, data memory and register file. It also handles fetch and data-memory wait states, detects illegal instructions and memory timeouts, and counts retired instructions.

---
 rtl/rv32_multicycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_rv32_multicycle_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/wb sequencing, 3-5 cycles per instruction plus wait states.
// Stalls in FETCH/MEM while imem_ready/dmem_ready are low; traps after TIMEOUT_CYCLES consecutive waits.
module rv32_multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic [3:0]           dec_alu_control,
    input  logic                 dec_reg_write,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_branch,
    input  logic                 branch_taken,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 alu_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic                 rf_wsel,
    output logic                 busy,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    localparam int            WW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic                   is_load_q, is_load_d;
    logic                   is_store_q, is_store_d;
    logic                   is_branch_q, is_branch_d;
    logic                   reg_write_q, reg_write_d;
    logic [1:0]             trap_cause_q, trap_cause_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   retire;
    logic [WW-1:0]          wait_inc;

    // Saturating so a long stall can never alias back below the timeout threshold.
    assign wait_inc = (&wait_q) ? wait_q : wait_q + WW'(1);

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        is_branch_d  = is_branch_q;
        reg_write_d  = reg_write_q;
        trap_cause_d = trap_cause_q;
        retire       = 1'b0;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = 1'b0;
        trap         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b01;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                // A load+store combination is resolved as a load here.
                is_load_d   = dec_mem_read;
                is_store_d  = dec_mem_write & ~dec_mem_read;
                is_branch_d = dec_branch;
                reg_write_d = dec_reg_write;
                if (dec_alu_control == 4'hF ||
                    !(dec_reg_write | dec_mem_read | dec_mem_write | dec_branch)) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                if (is_branch_q) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_load_q | is_store_q) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_q;
                if (dmem_ready) begin
                    if (is_load_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b11;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB: begin
                rf_we   = reg_write_q;
                rf_wsel = is_load_q;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        retired_d = retired_q + CNT_WIDTH'(retire);
    end

    assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                           (state_q == S_MEM)   || (state_q == S_WB);
    assign trap_cause    = trap_cause_q;
    assign state         = state_q;
    assign retired_count = retired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            is_branch_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            trap_cause_q <= 2'b00;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            is_branch_q  <= is_branch_d;
            reg_write_q  <= reg_write_d;
            trap_cause_q <= trap_cause_d;
            retired_q    <= retired_d;
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_controller.sv
// Directed bench for the multi-cycle controller: instruction classes, wait states, traps and reset.
module tb_rv32_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_ready, dmem_ready;
    logic [3:0]  dec_alu_control;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, branch_taken;
    logic        imem_req, ir_we, pc_we, pc_sel, alu_en, dmem_req, dmem_we, rf_we, rf_wsel;
    logic        busy, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_multicycle_controller #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dec_alu_control(dec_alu_control), .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_branch(dec_branch), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .rf_wsel(rf_wsel), .busy(busy),
        .trap(trap), .trap_cause(trap_cause), .state(state), .retired_count(retired_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dec(input logic [3:0] alu, input logic rw, input logic mr, input logic mw, input logic br);
        dec_alu_control = alu;
        dec_reg_write   = rw;
        dec_mem_read    = mr;
        dec_mem_write   = mw;
        dec_branch      = br;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        set_dec(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        check_eq("rst_state", state, 0);
        check_eq("rst_outs", {imem_req, ir_we, pc_we, alu_en, dmem_req, rf_we, busy, trap}, 0);
        check_eq("rst_cause", trap_cause, 0);
        check_eq("rst_count", retired_count, 0);

        // R-type add, no wait states
        rst_n = 1'b1; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        set_dec(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); start = 1'b0; #1;
        check_eq("r_fetch", {state, imem_req, ir_we, busy}, {3'd1, 3'b111});
        step();
        check_eq("r_decode", {state, alu_en}, {3'd2, 1'b0});
        step();
        check_eq("r_exec", {state, alu_en, pc_we}, {3'd3, 2'b10});
        step();
        check_eq("r_wb", {state, rf_we, rf_wsel, pc_we, pc_sel}, {3'd5, 4'b1010});
        step();
        check_eq("r_done", {29'd0, state}, 1);
        check_eq("r_count", retired_count, 1);

        // Load with both mem flags set and 3 dmem wait cycles
        set_dec(4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        dmem_ready = 1'b0;
        step(); step(); step();
        check_eq("ld_mem", {state, dmem_req, dmem_we}, {3'd4, 2'b10});
        for (int i = 0; i < 3; i++) step();
        check_eq("ld_mem_hold", state, 4);
        dmem_ready = 1'b1;
        step();
        check_eq("ld_wb", {state, rf_we, rf_wsel}, {3'd5, 2'b11});
        step();
        check_eq("ld_done", state, 1);
        check_eq("ld_count", retired_count, 2);

        // Store then taken branch
        set_dec(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(); step(); step();
        check_eq("st_mem", {state, dmem_req, dmem_we, pc_we, pc_sel, rf_we}, {3'd4, 5'b11100});
        step();
        check_eq("st_done", state, 1);
        check_eq("st_count", retired_count, 3);
        set_dec(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        branch_taken = 1'b1;
        step(); step();
        check_eq("br_exec", {state, alu_en, pc_we, pc_sel}, {3'd3, 3'b111});
        step();
        check_eq("br_done", state, 1);
        check_eq("br_count", retired_count, 4);
        branch_taken = 1'b0;

        // Illegal ALU op
        set_dec(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ill_fetch_pc", pc_we, 0);
        step();
        check_eq("ill_dec_pc", {state, pc_we}, {3'd2, 1'b0});
        step();
        check_eq("ill_trap", {state, trap, trap_cause, busy, pc_we}, {3'd6, 1'b1, 2'b10, 2'b00});
        start = 1'b1;
        step(); step();
        check_eq("ill_hold", {state, trap_cause}, {3'd6, 2'b10});
        do_reset();
        #1;
        check_eq("ill_reset", {state, trap, trap_cause}, 0);
        check_eq("ill_reset_cnt", retired_count, 0);

        // No control flags set is also illegal
        set_dec(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        check_eq("noflag_trap", {state, trap_cause}, {3'd6, 2'b10});
        do_reset();

        // Fetch timeout after 16 FETCH cycles
        imem_ready = 1'b0;
        set_dec(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step(); start = 1'b0; #1;
        check_eq("fto_first", {state, imem_req, ir_we}, {3'd1, 2'b10});
        for (int i = 0; i < 15; i++) step();
        check_eq("fto_c16", {state, trap}, {3'd1, 1'b0});
        step();
        check_eq("fto_trap", {state, trap, trap_cause}, {3'd6, 1'b1, 2'b01});
        do_reset();

        // Ready on the 16th FETCH cycle wins over timeout
        start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        imem_ready = 1'b1; #1;
        check_eq("fto_ready_irwe", ir_we, 1);
        step();
        check_eq("fto_ready_dec", {state, trap}, {3'd2, 1'b0});
        step(); step(); step();
        check_eq("fto_ready_cnt", {state, retired_count[28:0]}, {3'd1, 29'd1});

        // Data memory timeout
        set_dec(4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 15; i++) step();
        check_eq("mto_c16", state, 4);
        step();
        check_eq("mto_trap", {state, trap, trap_cause}, {3'd6, 1'b1, 2'b11});
        do_reset();

        // Reset while in MEM drops the request without retiring
        start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        check_eq("rmem_req", {state, dmem_req}, {3'd4, 1'b1});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; #1;
        check_eq("rmem_idle", {state, dmem_req, busy}, 0);
        check_eq("rmem_count", retired_count, 0);

        // start mid-FETCH is ignored
        imem_ready = 1'b0;
        start = 1'b1;
        step();
        step(); step();
        check_eq("start_fetch", {state, ir_we, busy}, {3'd1, 2'b01});
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
